uart_tx_periph: RTL and testbench

- Memory-mapped UART transmit peripheral.
- It is a bus responder to the CPU's MEM-stage peripheral port: rd/wr/addr/wdata in, rdata out.
- Bytes written by the CPU are queued in a small FIFO and serialized as 8N1 frames on tx.
- A maskable interrupt is raised on frame completion, feeding the CPU's IRQ path.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_periph.sv | 145 ++++++++++++++
 tb/tb_uart_tx_periph.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map, CON bit positions and FSM states for the UART transmit peripheral
package uart_pkg;
   localparam int CON_IRQ_EN  = 0;
   localparam int CON_DONE    = 2;
   localparam int CON_FULL    = 3;
   localparam int CON_BUSY    = 4;
   localparam int CON_OVF     = 5;
   localparam int CON_CNT_LSB = 6;
   localparam logic [31:0] TXD_OFF = 32'h0;
   localparam logic [31:0] CON_OFF = 32'h8;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is accepted only when a pop happens the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic push_ok, pop_ok;
   assign full    = count_q == (AW+1)'(DEPTH);
   assign empty   = count_q == '0;
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   // next storage, pointers (wrapping at DEPTH) and occupancy
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end
   // pointer and count registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // data storage needs no reset; entries are only read after being written
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TXD/CON registers, FIFO and maskable done interrupt
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
   parameter int          BAUD_DIV   = 5208,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_e state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d, last_txd_q, last_txd_d, fifo_rdata;
   logic tx_q, tx_d, irq_q, irq_d, irq_en_q, irq_en_d, done_q, done_d, ovf_q, ovf_d;
   logic hit_txd, hit_con, wr_txd, wr_con, pop, frame_end, baud_end, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0] con_val;
   logic unused_wdata;
   assign unused_wdata = ^wdata[31:8];
   assign hit_txd  = addr == BASE_ADDR + TXD_OFF;
   assign hit_con  = addr == BASE_ADDR + CON_OFF;
   assign wr_txd   = wr & hit_txd;
   assign wr_con   = wr & hit_con;
   assign baud_end = baud_q == 16'(BAUD_DIV - 1);
   assign rdata    = !rd ? '0 : hit_txd ? {24'b0, last_txd_q} : hit_con ? con_val : '0;
   assign tx       = tx_q;
   assign irq      = irq_q;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txd),
      .pop   (pop),
      .wdata (wdata[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // CON read view assembled from status flags
   always_comb begin
      con_val = '0;
      con_val[CON_IRQ_EN] = irq_en_q;
      con_val[CON_DONE] = done_q;
      con_val[CON_FULL] = fifo_full;
      con_val[CON_BUSY] = state_q != IDLE;
      con_val[CON_OVF] = ovf_q;
      con_val[CON_CNT_LSB +: 4] = 4'(fifo_count);
   end

   // frame sequencer: every bit lasts BAUD_DIV cycles, STOP chains straight into the next START
   always_comb begin
      state_d = state_q;
      baud_d = baud_q + 16'd1;
      bit_d = bit_q;
      shift_d = shift_q;
      tx_d = tx_q;
      pop = 1'b0;
      frame_end = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop = 1'b1;
               shift_d = fifo_rdata;
               state_d = START;
               tx_d = 1'b0;
            end
         end
         START: if (baud_end) begin
            baud_d = '0;
            bit_d = '0;
            state_d = DATA;
            tx_d = shift_q[0];
         end
         DATA: if (baud_end) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
               state_d = STOP;
               tx_d = 1'b1;
            end else begin
               shift_d = shift_q >> 1;
               bit_d = bit_q + 3'd1;
               tx_d = shift_d[0];
            end
         end
         STOP: if (baud_end) begin
            baud_d = '0;
            frame_end = 1'b1;
            pop = !fifo_empty;
            shift_d = fifo_empty ? shift_q : fifo_rdata;
            state_d = fifo_empty ? IDLE : START;
            tx_d = fifo_empty;
         end
      endcase
   end

   // register-side updates: set beats W1C clear for tx_done, overflow only when the push is really dropped
   always_comb begin
      irq_en_d = wr_con ? wdata[CON_IRQ_EN] : irq_en_q;
      done_d = frame_end | (done_q & ~(wr_con & wdata[CON_DONE]));
      ovf_d = (wr_txd & fifo_full & ~pop) | (ovf_q & ~(wr_con & wdata[CON_OVF]));
      last_txd_d = wr_txd ? wdata[7:0] : last_txd_q;
      irq_d = irq_en_q & done_q;
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         tx_q <= 1'b1;
         irq_q <= 1'b0;
         irq_en_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
         last_txd_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q <= baud_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         tx_q <= tx_d;
         irq_q <= irq_d;
         irq_en_q <= irq_en_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
         last_txd_q <= last_txd_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: scoreboard bench for the UART transmit peripheral with BAUD_DIV=4, FIFO_DEPTH=4
module tb_uart_tx_periph;
   localparam int BD = 4;
   localparam logic [31:0] TXD = 32'h4000_0018;
   localparam logic [31:0] CON = 32'h4000_0020;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rd = 1'b0;
   logic wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic tx, irq;
   logic [7:0] sb[$];
   int passed = 0;
   int total = 0;

   uart_tx_periph #(.BASE_ADDR(32'h4000_0018), .BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .rd    (rd),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .tx    (tx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      wr = 1'b1;
      addr = a;
      wdata = d;
      @(posedge clk);
      #1 wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      rd = 1'b1;
      addr = a;
      #1 d = rdata;
      rd = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string nm);
      logic [7:0] b;
      logic [9:0] f;
      logic e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty, no expected byte", nm);
         return;
      end
      b = sb.pop_front();
      f = {1'b1, b, 1'b0};
      for (int k = 0; k < 10 * BD; k++) begin
         step();
         e = f[k / BD];
         total++;
         if (tx !== e) $display("FAIL %s byte %h cycle %0d: tx=%b expected %b", nm, b, k, tx, e);
         else passed++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) step();
      total++;
      if (tx !== 1'b1) $display("FAIL reset_tx: tx=%b expected 1", tx); else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL reset_irq: irq=%b expected 0", irq); else passed++;
      reset = 1'b0;
      bus_read(CON, d);
      total++;
      if (d !== 32'h0) $display("FAIL reset_con: got %h expected 0", d); else passed++;
      bus_read(TXD, d);
      total++;
      if (d !== 32'h0) $display("FAIL reset_txd: got %h expected 0", d); else passed++;
   endtask

   task automatic test_single_frame();
      logic [31:0] d;
      sb.push_back(8'h55);
      bus_write(TXD, 32'h55);
      check_frame("single_55");
      bus_read(CON, d);
      total++;
      if (d !== 32'h10) $display("FAIL single_con_stop: got %h expected 00000010", d); else passed++;
      step();
      bus_read(CON, d);
      total++;
      if (d !== 32'h04) $display("FAIL single_con_done: got %h expected 00000004", d); else passed++;
      bus_write(CON, 32'h4);
      bus_read(CON, d);
      total++;
      if (d !== 32'h0) $display("FAIL single_done_clear: got %h expected 0", d); else passed++;
   endtask

   task automatic test_irq();
      logic [31:0] d;
      bus_write(CON, 32'h1);
      sb.push_back(8'hA3);
      bus_write(TXD, 32'hA3);
      check_frame("irq_a3");
      step();
      total++;
      if (irq !== 1'b0) $display("FAIL irq_lag: irq=%b expected 0", irq); else passed++;
      bus_read(CON, d);
      total++;
      if (d !== 32'h05) $display("FAIL irq_con: got %h expected 00000005", d); else passed++;
      step();
      total++;
      if (irq !== 1'b1) $display("FAIL irq_rise: irq=%b expected 1", irq); else passed++;
      bus_write(CON, 32'h4);
      total++;
      if (irq !== 1'b1) $display("FAIL irq_hold: irq=%b expected 1", irq); else passed++;
      step();
      total++;
      if (irq !== 1'b0) $display("FAIL irq_fall: irq=%b expected 0", irq); else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
      bus_write(TXD, 32'h01);
      fork
         begin
            for (int i = 2; i <= 6; i++) bus_write(TXD, 32'(i));
            bus_read(CON, d);
            total++;
            if (d !== 32'h138) $display("FAIL ovf_con: got %h expected 00000138", d); else passed++;
            bus_read(TXD, d);
            total++;
            if (d !== 32'h06) $display("FAIL ovf_last_txd: got %h expected 00000006", d); else passed++;
         end
         repeat (5) check_frame("ovf_b2b");
      join
      step();
      bus_read(CON, d);
      total++;
      if (d !== 32'h24) $display("FAIL ovf_end_con: got %h expected 00000024", d); else passed++;
      bus_write(CON, 32'h24);
      bus_read(CON, d);
      total++;
      if (d !== 32'h0) $display("FAIL ovf_clear: got %h expected 0", d); else passed++;
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      for (int i = 0; i < 6; i++) sb.push_back(8'h10 + 8'(i));
      bus_write(TXD, 32'h10);
      fork
         begin
            for (int i = 1; i <= 4; i++) bus_write(TXD, 32'h10 + 32'(i));
            repeat (36) step();
            bus_write(TXD, 32'h15);
            bus_read(CON, d);
            total++;
            if (d !== 32'h11C) $display("FAIL full_pushpop_con: got %h expected 0000011c", d); else passed++;
         end
         repeat (6) check_frame("full_pushpop");
      join
      step();
      bus_read(CON, d);
      total++;
      if (d !== 32'h04) $display("FAIL full_end_con: got %h expected 00000004", d); else passed++;
      bus_write(CON, 32'h4);
   endtask

   task automatic test_con_read();
      logic [31:0] d;
      for (int i = 0; i < 3; i++) sb.push_back(8'h20 + 8'(i));
      bus_write(TXD, 32'h20);
      fork
         begin
            bus_write(TXD, 32'h21);
            bus_write(TXD, 32'h22);
            bus_read(CON, d);
            total++;
            if (d !== 32'h90) $display("FAIL con_busy_cnt2: got %h expected 00000090", d); else passed++;
            bus_read(32'h4000_001C, d);
            total++;
            if (d !== 32'h0) $display("FAIL read_unmapped: got %h expected 0", d); else passed++;
            addr = CON;
            #1;
            total++;
            if (rdata !== 32'h0) $display("FAIL read_no_rd: got %h expected 0", rdata); else passed++;
         end
         repeat (3) check_frame("con_frames");
      join
      step();
      bus_read(CON, d);
      total++;
      if (d !== 32'h04) $display("FAIL con_end: got %h expected 00000004", d); else passed++;
      bus_write(CON, 32'h4);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic stayed_high;
      bus_write(TXD, 32'hA5);
      bus_write(TXD, 32'h33);
      repeat (17) step();
      total++;
      if (tx !== 1'b0) $display("FAIL mid_bit3_before_reset: tx=%b expected 0", tx); else passed++;
      reset = 1'b1;
      step();
      total++;
      if (tx !== 1'b1) $display("FAIL mid_reset_tx: tx=%b expected 1", tx); else passed++;
      reset = 1'b0;
      bus_read(CON, d);
      total++;
      if (d !== 32'h0) $display("FAIL mid_reset_con: got %h expected 0", d); else passed++;
      bus_read(TXD, d);
      total++;
      if (d !== 32'h0) $display("FAIL mid_reset_txd: got %h expected 0", d); else passed++;
      stayed_high = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1) stayed_high = 1'b0;
      end
      total++;
      if (stayed_high !== 1'b1) $display("FAIL mid_reset_no_frames: tx went low=%b expected stay high", ~stayed_high); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_irq();
      test_overflow();
      test_full_push_pop();
      test_con_read();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
